// File: rtl/chunked_seq_adder_pkg.sv
// Shared definitions for the chunked sequential adder: FSM encoding and
// helpers that derive the chunk count and index width from the parameters.
package chunked_seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of CHUNK-wide slices in a WIDTH-wide operand.
  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Chunk index width; at least one bit so the index register always exists.
  function automatic int calc_idxw(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

  // Legal configuration: 1 <= CHUNK <= WIDTH and WIDTH an exact multiple of CHUNK.
  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunked_seq_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple adder; the only carry chain in the design,
// so its length (CHUNK) sets the critical path.
module chunked_seq_adder_chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);

  logic [CHUNK:0] carry;

  assign carry[0] = cin_i;

  // One full-adder cell per bit, carry rippling from LSB to MSB.
  genvar gi;
  generate
    for (gi = 0; gi < CHUNK; gi++) begin : g_bit
      chunked_seq_adder_one_bit_adder u_fa (
        .a_i    (a_i[gi]),
        .b_i    (b_i[gi]),
        .cin_i  (carry[gi]),
        .sum_o  (sum_o[gi]),
        .cout_o (carry[gi+1])
      );
    end
  endgenerate

  assign cout_o = carry[CHUNK];

endmodule

// File: rtl/chunked_seq_adder_one_bit_adder.sv
// Single full-adder cell, the building block of the chunk ripple chain.
module chunked_seq_adder_one_bit_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/chunked_seq_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: processes CHUNK bits per cycle
// through one registered carry, with valid/ready handshakes and status flags.
module chunked_seq_adder
  import chunked_seq_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDXW   = calc_idxw(NCHUNK);
  localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});
  localparam int MSB = WIDTH - 1;

  generate
    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("chunked_seq_adder: WIDTH must be a multiple of CHUNK and CHUNK in 1..WIDTH");
    end
  endgenerate

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             cout_q;
  logic             overflow_q;
  logic             zero_q;

  logic [31:0]      base_bit;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] sum_chunk;
  logic             carry_d;
  logic [WIDTH-1:0] sum_d;

  // Select the current chunk of each operand and merge the chunk result back into sum.
  always_comb begin
    base_bit  = 32'(idx_q) * 32'(CHUNK);
    a_chunk   = CHUNK'(a_q >> base_bit);
    b_chunk   = CHUNK'(b_q >> base_bit);
    sum_d     = (sum_q & ~(CHUNK_MASK << base_bit)) | (WIDTH'(sum_chunk) << base_bit);
  end

  chunked_seq_adder_chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a_i    (a_chunk),
    .b_i    (b_chunk),
    .cin_i  (carry_q),
    .sum_o  (sum_chunk),
    .cout_o (carry_d)
  );

  // Control FSM: capture operands, walk the chunks, then hold the result until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1, so the carry-in is forced and cin ignored.
            a_q        <= a;
            b_q        <= sub ? ~b : b;
            carry_q    <= sub ? 1'b1 : cin;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
          idx_q   <= idx_q + IDXW'(1);
          if (idx_q == LAST_IDX) begin
            idx_q       <= '0;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            cout_q      <= carry_d;
            overflow_q  <= (a_q[MSB] == b_q[MSB]) && (sum_d[MSB] != a_q[MSB]);
            zero_q      <= (sum_d == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule
